// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side engine popping a programmed byte count from the SRAM FIFO onto a valid/ready stream
module fifo_reader #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_start,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_we_n,
    output logic                  fifo_oe_n,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_WIDTH:0] remaining;
    logic                inflight;
    logic [1:0]          buf_cnt;
    logic [WIDTH-1:0]    buf0;
    logic [WIDTH-1:0]    buf1;
    logic                pop;
    logic                accept;
    logic                flush_ok;
    logic [2:0]          credit;

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pop gating: a pop is allowed only if the byte it fetches is guaranteed a buffer slot,
    // counting bytes buffered, the one in flight, and the one leaving this cycle.
    always_comb begin
        accept   = m_valid && m_ready;
        credit   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, accept};
        pop      = (state == S_READ) && (remaining != '0) && !fifo_empty && (credit < 3'd2);
        flush_ok = !inflight && (buf_cnt == 2'd0);
    end

    assign fifo_oe_n = !pop;
    assign fifo_we_n = 1'b1;
    assign busy      = (state != S_IDLE);
    assign m_valid   = (buf_cnt != 2'd0);
    assign m_data    = buf0;

    // State register plus the registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == S_FLUSH) && flush_ok;
        end
    end

    // Next-state logic: zero-length commands skip straight to the drain state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    state_nxt = (cmd_len == '0) ? S_FLUSH : S_READ;
                end
            end
            S_READ: begin
                if (remaining == '0) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte countdown and the one-cycle SRAM read latency marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= pop;
            if (state == S_IDLE) begin
                if (cmd_start) begin
                    remaining <= cmd_len;
                end
            end else if (pop) begin
                remaining <= remaining - ONE;
            end
        end
    end

    // Two-entry output buffer: buf0 is the head, captured data lands behind any held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            case ({inflight, accept})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf1 <= fifo_dout;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout;
                    end
                end
                default: begin
                    buf_cnt <= buf_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard testbench for fifo_reader with a behavioural SRAM FIFO
module tb_fifo_reader;

    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_start;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_we_n;
    logic                  fifo_oe_n;
    logic [WIDTH-1:0]      fifo_dout;
    logic                  fifo_empty;
    logic [WIDTH-1:0]      m_data;
    logic                  m_valid;
    logic                  m_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    int acc_cnt  = 0;
    int lost_cnt = 0;
    int done_cnt = 0;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] sb_q[$];

    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    fifo_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_start  (cmd_start),
        .cmd_len    (cmd_len),
        .busy       (busy),
        .done       (done),
        .fifo_we_n  (fifo_we_n),
        .fifo_oe_n  (fifo_oe_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Behavioural SRAM FIFO: data appears the cycle after the pop edge.
    assign fifo_empty = (fq.size() == 0);
    always @(posedge clk) begin
        if (rst_n && !fifo_oe_n) begin
            n_checks++;
            if (fq.size() == 0) begin
                n_fail++;
                $display("FAIL pop_when_empty: got pop expected none");
            end else begin
                fifo_dout <= fq.pop_front();
                pop_cnt++;
            end
        end
    end

    // Monitor: compares each accepted beat against the scoreboard and checks stall behaviour.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", {31'd0, m_valid}, 32'd1);
                check("stall_hold_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            check("outstanding_le_2", {31'd0, ((pop_cnt - acc_cnt - lost_cnt) <= 2)}, 32'd1);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
                end else begin
                    check("beat_data", {24'd0, m_data}, {24'd0, sb_q.pop_front()});
                end
                acc_cnt++;
            end
            if (done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int len);
        cmd_len   = len[ADDR_WIDTH:0];
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) break;
            tick();
        end
        check(name, done_cnt - d0, 1);
    endtask

    logic [31:0] pat;
    int          pc0;
    int          ac0;

    initial begin
        rst_n     = 1'b0;
        cmd_start = 1'b0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        fifo_dout = '0;
        pat       = 32'b1001_1101_0011_0001_1110_0100_1011_0111;
        repeat (3) tick();

        // Reset values
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_oe_n", {31'd0, fifo_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, fifo_we_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero-length command: busy next cycle, done two cycles after start, no pops
        pc0 = pop_cnt;
        issue(0);
        check("len0_busy", {31'd0, busy}, 32'd1);
        check("len0_done_early", {31'd0, done}, 32'd0);
        tick();
        check("len0_done", {31'd0, done}, 32'd1);
        tick();
        check("len0_done_pulse", {31'd0, done}, 32'd0);
        check("len0_busy_end", {31'd0, busy}, 32'd0);
        check("len0_no_pops", pop_cnt - pc0, 0);

        // 16 bytes at full throughput
        for (int i = 1; i <= 16; i++) begin
            fq.push_back(i[7:0]);
            sb_q.push_back(i[7:0]);
        end
        m_ready = 1'b1;
        pc0 = pop_cnt;
        ac0 = acc_cnt;
        issue(16);
        check("lat_first_pop", {31'd0, fifo_oe_n}, 32'd0);
        check("lat_valid_c1", {31'd0, m_valid}, 32'd0);
        tick();
        check("lat_valid_c2", {31'd0, m_valid}, 32'd0);
        tick();
        check("lat_valid_c3", {31'd0, m_valid}, 32'd1);
        check("lat_first_data", {24'd0, m_data}, 32'h01);
        repeat (16) tick();
        check("full_rate_16", acc_cnt - ac0, 16);
        wait_done("full_rate_done", 10);
        check("full_rate_pops", pop_cnt - pc0, 16);
        check("full_rate_fifo_empty", fq.size(), 0);
        check("full_rate_sb_empty", sb_q.size(), 0);
        tick();

        // Same stream with a 1-0-0-1 style ready pattern
        for (int i = 0; i < 16; i++) begin
            fq.push_back(8'h11 + i[7:0]);
            sb_q.push_back(8'h11 + i[7:0]);
        end
        ac0 = acc_cnt;
        m_ready = 1'b1;
        issue(16);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            m_ready = pat[i % 32];
            tick();
        end
        m_ready = 1'b1;
        check("stall_all_accepted", acc_cnt - ac0, 16);
        check("stall_sb_empty", sb_q.size(), 0);
        check("stall_idle", {31'd0, busy}, 32'd0);
        tick();

        // Underrun: 3 bytes available, 5 requested, extra start ignored while busy
        for (int i = 0; i < 3; i++) begin
            fq.push_back(8'hA1 + i[7:0]);
            sb_q.push_back(8'hA1 + i[7:0]);
        end
        pc0 = pop_cnt;
        ac0 = acc_cnt;
        d_cnt_issue();
        repeat (10) tick();
        check("under_busy", {31'd0, busy}, 32'd1);
        check("under_three", acc_cnt - ac0, 3);
        check("under_oe_idle", {31'd0, fifo_oe_n}, 32'd1);
        issue(9);
        tick();
        check("under_start_ignored", acc_cnt - ac0, 3);
        fq.push_back(8'hA4);
        fq.push_back(8'hA5);
        sb_q.push_back(8'hA4);
        sb_q.push_back(8'hA5);
        wait_done("under_done", 20);
        check("under_five", acc_cnt - ac0, 5);
        check("under_pops", pop_cnt - pc0, 5);
        repeat (3) tick();
        check("under_idle", {31'd0, busy}, 32'd0);

        // Reset mid-command with two bytes held in the buffer
        for (int i = 0; i < 8; i++) fq.push_back(8'h50 + i[7:0]);
        m_ready = 1'b0;
        pc0 = pop_cnt;
        issue(6);
        repeat (5) tick();
        check("rst_mid_pops", pop_cnt - pc0, 2);
        check("rst_mid_valid_before", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
        check("rst_mid_oe_n", {31'd0, fifo_oe_n}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        lost_cnt = pop_cnt - acc_cnt;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 2; i < 5; i++) sb_q.push_back(8'h50 + i[7:0]);
        m_ready = 1'b1;
        ac0 = acc_cnt;
        issue(3);
        wait_done("post_rst_done", 20);
        check("post_rst_beats", acc_cnt - ac0, 3);
        check("post_rst_sb_empty", sb_q.size(), 0);
        check("post_rst_fifo_left", fq.size(), 3);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic d_cnt_issue();
        m_ready = 1'b1;
        issue(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
